note_tone_generator: RTL and testbench

//  Square-wave note generator downstream of the melody player: it takes one note per request
//  and produces a tone with a given half-period (us) for a given duration (ms).
//  It reports busy, then pulses done so the player can fetch the next note.
//  Its output drives the buzzer pin directly.

---
 rtl/note_tone_generator_if.sv | 37 +++
 rtl/note_tone_generator.sv | 122 ++++++++++++
 tb/tb_note_tone_generator.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/note_tone_generator_if.sv
// Note request / tone status bundle between the melody player and the tone generator.
//   Request_i       one-cycle note start strobe (player -> generator)
//   Abort_i         level, stops the current note (player -> generator)
//   Duration_ms_i   note length in ms (player -> generator)
//   HalfPeriod_us_i tone half-period in us, 0 = rest (player -> generator)
//   SoundWave_o     registered square wave for the buzzer pin (generator -> player/pin)
//   Busy_o          high while a note is playing (generator -> player)
//   Done_o          one-cycle pulse on normal completion (generator -> player)
interface note_tone_generator_if;
  logic        Request_i;
  logic        Abort_i;
  logic [15:0] Duration_ms_i;
  logic [15:0] HalfPeriod_us_i;
  logic        SoundWave_o;
  logic        Busy_o;
  logic        Done_o;

  modport master (
    output Request_i,
    output Abort_i,
    output Duration_ms_i,
    output HalfPeriod_us_i,
    input  SoundWave_o,
    input  Busy_o,
    input  Done_o
  );

  modport slave (
    input  Request_i,
    input  Abort_i,
    input  Duration_ms_i,
    input  HalfPeriod_us_i,
    output SoundWave_o,
    output Busy_o,
    output Done_o
  );
endinterface

// File: rtl/note_tone_generator.sv
// Square-wave note generator. Accepts one note per request in idle, plays a tone of the latched
// half-period (us) for the latched duration (ms), then pulses Done_o.
//   Clock  system clock, rising edge
//   Reset  asynchronous, active-low
//   bus    note_tone_generator_if.slave: request/abort/duration/half-period in,
//          SoundWave_o/Busy_o/Done_o out (all registered)
module note_tone_generator #(
  parameter int unsigned CLOCK_HZ = 10_000_000
) (
  input logic                 Clock,
  input logic                 Reset,
  note_tone_generator_if.slave bus
);

  localparam int unsigned US_TICKS = CLOCK_HZ / 1_000_000;
  localparam int unsigned UsW      = (US_TICKS > 1) ? $clog2(US_TICKS) : 1;
  localparam logic [UsW-1:0] UsLast = UsW'(US_TICKS - 1);

  typedef enum logic [0:0] {StIdle, StPlaying} state_e;

  state_e         state_q, state_d;
  logic [UsW-1:0] us_cnt_q, us_cnt_d;
  logic [9:0]     ms_cnt_q, ms_cnt_d;
  logic [15:0]    hp_cnt_q, hp_cnt_d;
  logic [15:0]    remain_q, remain_d;
  logic [15:0]    hp_q, hp_d;
  logic           wave_q, wave_d;
  logic           done_q, done_d;

  logic us_tick, ms_tick;

  assign us_tick = (us_cnt_q == UsLast);
  assign ms_tick = us_tick && (ms_cnt_q == 10'd999);

  always_comb begin
    state_d  = state_q;
    us_cnt_d = us_cnt_q;
    ms_cnt_d = ms_cnt_q;
    hp_cnt_d = hp_cnt_q;
    remain_d = remain_q;
    hp_d     = hp_q;
    wave_d   = wave_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.Request_i && !bus.Abort_i) begin
          hp_d     = bus.HalfPeriod_us_i;
          remain_d = bus.Duration_ms_i;
          us_cnt_d = '0;
          ms_cnt_d = '0;
          hp_cnt_d = '0;
          wave_d   = 1'b0;
          if (bus.Duration_ms_i != 16'd0) begin
            state_d = StPlaying;
          end else begin
            // Zero-length note completes immediately without ever going busy.
            done_d = 1'b1;
          end
        end
      end

      StPlaying: begin
        if (bus.Abort_i) begin
          // Abort has priority over a coinciding final ms tick: no Done_o.
          state_d = StIdle;
          wave_d  = 1'b0;
        end else begin
          us_cnt_d = us_tick ? '0 : us_cnt_q + 1'b1;
          if (us_tick) begin
            ms_cnt_d = ms_tick ? 10'd0 : ms_cnt_q + 10'd1;
            if (hp_q != 16'd0) begin
              if (hp_cnt_q == hp_q - 16'd1) begin
                wave_d   = ~wave_q;
                hp_cnt_d = 16'd0;
              end else begin
                hp_cnt_d = hp_cnt_q + 16'd1;
              end
            end
          end
          if (ms_tick) begin
            remain_d = remain_q - 16'd1;
            if (remain_q == 16'd1) begin
              state_d = StIdle;
              wave_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= StIdle;
      us_cnt_q <= '0;
      ms_cnt_q <= '0;
      hp_cnt_q <= '0;
      remain_q <= '0;
      hp_q     <= '0;
      wave_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      us_cnt_q <= us_cnt_d;
      ms_cnt_q <= ms_cnt_d;
      hp_cnt_q <= hp_cnt_d;
      remain_q <= remain_d;
      hp_q     <= hp_d;
      wave_q   <= wave_d;
      done_q   <= done_d;
    end
  end

  assign bus.SoundWave_o = wave_q;
  assign bus.Busy_o      = (state_q == StPlaying);
  assign bus.Done_o      = done_q;

endmodule

// File: tb/tb_note_tone_generator.sv
module tb_note_tone_generator;

  localparam int U = 2;  // clock cycles per us at 2 MHz

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  int   checks = 0;
  int   passes = 0;

  note_tone_generator_if bus();

  note_tone_generator #(.CLOCK_HZ(2_000_000)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  // Expected {wave, busy, done} n clock edges after the accepting edge, for a note lasting T
  // cycles with half-period H us, optionally aborted by the edge A (A < 0: no abort).
  function automatic logic [2:0] model(input int n, input int T, input int H, input int A);
    logic aborted, w, b, d;
    int   stop;
    aborted = (A >= 0) && (A <= T) && (T > 0);
    stop    = aborted ? A : T;
    b       = (n < stop);
    d       = !aborted && (n == T);
    w       = b && (H != 0) && (((n / (H * U)) % 2) == 1);
    return {w, b, d};
  endfunction

  task automatic start_note(input int dur, input int hp);
    bus.Duration_ms_i   = 16'(dur);
    bus.HalfPeriod_us_i = 16'(hp);
    bus.Request_i       = 1'b1;
    @(posedge Clock);
    #1;
    bus.Request_i       = 1'b0;
  endtask

  // Samples n = 0..cycles-1 (caller stands at n = 0), injecting an abort at edge A and an
  // ignored request at edge R; returns first deviation from the model plus summary counts.
  task automatic observe(input int cycles, input int T, input int H, input int A, input int R,
                         output int bad_n, output logic [2:0] bad_o, output logic [2:0] bad_e,
                         output int busy_cnt, output int toggles, output int done_cnt);
    logic [2:0] obs, exp;
    logic       prev_w;
    bad_n = -1; bad_o = '0; bad_e = '0;
    busy_cnt = 0; toggles = 0; done_cnt = 0; prev_w = 1'b0;
    for (int n = 0; n < cycles; n++) begin
      if (n > 0) begin
        @(posedge Clock);
        #1;
      end
      obs = {bus.SoundWave_o, bus.Busy_o, bus.Done_o};
      exp = model(n, T, H, A);
      if (obs !== exp && bad_n < 0) begin
        bad_n = n; bad_o = obs; bad_e = exp;
      end
      if (obs[2] !== prev_w) toggles++;
      prev_w = obs[2];
      if (obs[1] === 1'b1) busy_cnt++;
      if (obs[0] === 1'b1) done_cnt++;
      if (A >= 1 && n == A - 1) bus.Abort_i = 1'b1;
      if (A >= 1 && n == A) bus.Abort_i = 1'b0;
      if (R >= 1 && n == R - 1) begin
        bus.Duration_ms_i = 16'd9; bus.HalfPeriod_us_i = 16'd7; bus.Request_i = 1'b1;
      end
      if (R >= 1 && n == R) bus.Request_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [2:0] obs;
    int nonzero;
    checks++;
    obs = {bus.SoundWave_o, bus.Busy_o, bus.Done_o};
    if (obs === 3'b000) passes++;
    else $display("FAIL reset_initial: outputs %b, required 000", obs);
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    start_note(3, 250);
    for (int n = 1; n <= 700; n++) begin
      @(posedge Clock);
      #1;
    end
    checks++;
    obs = {bus.SoundWave_o, bus.Busy_o, bus.Done_o};
    if (obs === 3'b110) passes++;
    else $display("FAIL reset_prerun: outputs %b, required 110", obs);
    #2 Reset = 1'b0;
    #1;
    checks++;
    obs = {bus.SoundWave_o, bus.Busy_o, bus.Done_o};
    if (obs === 3'b000) passes++;
    else $display("FAIL reset_async: outputs %b, required 000", obs);
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    nonzero = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge Clock);
      #1;
      if ({bus.SoundWave_o, bus.Busy_o, bus.Done_o} !== 3'b000) nonzero++;
    end
    checks++;
    if (nonzero == 0) passes++;
    else $display("FAIL reset_idle: nonzero cycles %0d, required 0", nonzero);
  endtask

  task automatic test_tone();
    int bad_n, busy_cnt, toggles, done_cnt;
    logic [2:0] bad_o, bad_e;
    start_note(3, 250);
    observe(6010, 6000, 250, -1, -1, bad_n, bad_o, bad_e, busy_cnt, toggles, done_cnt);
    checks++;
    if (bad_n < 0) passes++;
    else $display("FAIL tone_trace: cycle %0d got %b, required %b", bad_n, bad_o, bad_e);
    checks++;
    if (busy_cnt == 6000) passes++;
    else $display("FAIL tone_busy: busy cycles %0d, required 6000", busy_cnt);
    checks++;
    if (toggles == 12) passes++;
    else $display("FAIL tone_toggles: toggles %0d, required 12", toggles);
    checks++;
    if (done_cnt == 1) passes++;
    else $display("FAIL tone_done: done pulses %0d, required 1", done_cnt);
  endtask

  task automatic test_rest();
    int bad_n, busy_cnt, toggles, done_cnt;
    logic [2:0] bad_o, bad_e;
    start_note(2, 0);
    observe(4010, 4000, 0, -1, -1, bad_n, bad_o, bad_e, busy_cnt, toggles, done_cnt);
    checks++;
    if (bad_n < 0) passes++;
    else $display("FAIL rest_trace: cycle %0d got %b, required %b", bad_n, bad_o, bad_e);
    checks++;
    if (busy_cnt == 4000 && toggles == 0 && done_cnt == 1) passes++;
    else $display("FAIL rest_counts: busy %0d toggles %0d done %0d, required 4000 0 1",
                  busy_cnt, toggles, done_cnt);
  endtask

  task automatic test_zero_duration();
    int bad_n, busy_cnt, toggles, done_cnt;
    logic [2:0] bad_o, bad_e;
    start_note(0, 100);
    observe(20, 0, 100, -1, -1, bad_n, bad_o, bad_e, busy_cnt, toggles, done_cnt);
    checks++;
    if (bad_n < 0) passes++;
    else $display("FAIL zero_trace: cycle %0d got %b, required %b", bad_n, bad_o, bad_e);
    checks++;
    if (busy_cnt == 0 && toggles == 0 && done_cnt == 1) passes++;
    else $display("FAIL zero_counts: busy %0d toggles %0d done %0d, required 0 0 1",
                  busy_cnt, toggles, done_cnt);
  endtask

  task automatic test_abort();
    int bad_n, busy_cnt, toggles, done_cnt, nonzero;
    logic [2:0] bad_o, bad_e;
    start_note(5, 100);
    observe(3010, 10000, 100, 3000, 1000, bad_n, bad_o, bad_e, busy_cnt, toggles, done_cnt);
    checks++;
    if (bad_n < 0) passes++;
    else $display("FAIL abort_trace: cycle %0d got %b, required %b", bad_n, bad_o, bad_e);
    checks++;
    if (busy_cnt == 3000 && done_cnt == 0) passes++;
    else $display("FAIL abort_counts: busy %0d done %0d, required 3000 0", busy_cnt, done_cnt);
    // Abort coinciding with the final ms tick.
    start_note(1, 50);
    observe(2010, 2000, 50, 2000, -1, bad_n, bad_o, bad_e, busy_cnt, toggles, done_cnt);
    checks++;
    if (bad_n < 0 && done_cnt == 0) passes++;
    else $display("FAIL abort_final: cycle %0d got %b, required %b, done %0d required 0",
                  bad_n, bad_o, bad_e, done_cnt);
    // Abort together with a request in idle drops the request.
    bus.Duration_ms_i = 16'd1; bus.HalfPeriod_us_i = 16'd10;
    bus.Request_i = 1'b1; bus.Abort_i = 1'b1;
    @(posedge Clock);
    #1;
    bus.Request_i = 1'b0; bus.Abort_i = 1'b0;
    nonzero = 0;
    for (int n = 0; n < 10; n++) begin
      if ({bus.SoundWave_o, bus.Busy_o, bus.Done_o} !== 3'b000) nonzero++;
      @(posedge Clock);
      #1;
    end
    checks++;
    if (nonzero == 0) passes++;
    else $display("FAIL abort_request_idle: active cycles %0d, required 0", nonzero);
  endtask

  task automatic test_back_to_back();
    int bad_n, busy_cnt, toggles, done_cnt, h1, h2;
    logic [2:0] bad_o, bad_e;
    h1 = int'($urandom_range(1, 300));
    h2 = int'($urandom_range(1, 300));
    start_note(1, h1);
    observe(2001, 2000, h1, -1, -1, bad_n, bad_o, bad_e, busy_cnt, toggles, done_cnt);
    checks++;
    if (bad_n < 0 && bus.Done_o === 1'b1 && bus.Busy_o === 1'b0) passes++;
    else $display("FAIL b2b_first: cycle %0d got %b, required %b (hp %0d)",
                  bad_n, bad_o, bad_e, h1);
    start_note(2, h2);
    observe(4005, 4000, h2, -1, -1, bad_n, bad_o, bad_e, busy_cnt, toggles, done_cnt);
    checks++;
    if (bad_n < 0) passes++;
    else $display("FAIL b2b_second: cycle %0d got %b, required %b (hp %0d)",
                  bad_n, bad_o, bad_e, h2);
    checks++;
    if (busy_cnt == 4000 && done_cnt == 1) passes++;
    else $display("FAIL b2b_counts: busy %0d done %0d, required 4000 1", busy_cnt, done_cnt);
  endtask

  task automatic test_random();
    int bad_n, busy_cnt, toggles, done_cnt, d, h, t, a, win;
    logic [2:0] bad_o, bad_e;
    for (int k = 0; k < 4; k++) begin
      d = int'($urandom_range(1, 2));
      h = int'($urandom_range(0, 400));
      t = d * 1000 * U;
      a = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, t)) : -1;
      win = ((a >= 0) ? a : t) + 6;
      start_note(d, h);
      observe(win, t, h, a, -1, bad_n, bad_o, bad_e, busy_cnt, toggles, done_cnt);
      checks++;
      if (bad_n < 0) passes++;
      else $display("FAIL random_%0d: dur %0d hp %0d abort %0d cycle %0d got %b, required %b",
                    k, d, h, a, bad_n, bad_o, bad_e);
    end
  endtask

  initial begin
    bus.Request_i = 1'b0;
    bus.Abort_i = 1'b0;
    bus.Duration_ms_i = '0;
    bus.HalfPeriod_us_i = '0;
    #1;
    test_reset();
    test_tone();
    test_rest();
    test_zero_duration();
    test_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
